// File: rtl/spike_rate_decoder.sv
// Four-channel spike rate decoder: counts spikes per channel over a 2^WIN_LOG2-cycle window
// and latches the counts with a valid/ready handshake. Optional SPIKE_DEC_THRESH_EN adds threshold flags.
module spike_rate_decoder #(
    parameter int unsigned WIN_LOG2 = 8,
    parameter logic [7:0]  THRESH   = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [3:0] spike_in,
    input  logic [1:0] sel,
    output logic [7:0] rate_out,
    output logic       rate_valid,
    input  logic       rate_ready,
    output logic       window_tick,
    output logic       overrun,
    output logic [3:0] thresh_hit
);

    localparam logic [WIN_LOG2-1:0] TIMER_LAST = '1;
    localparam logic [WIN_LOG2-1:0] TIMER_ONE  = WIN_LOG2'(1);

    logic [WIN_LOG2-1:0] timer;
    logic [3:0][7:0]     cnt;
    logic [3:0][7:0]     cnt_next;
    logic [3:0][7:0]     lat;
    logic                win_end;

    assign win_end = ena && (timer == TIMER_LAST);

    // Saturating increment; also used as the latch value so a spike in the last window cycle counts.
    always_comb begin
        cnt_next = cnt;
        for (int i = 0; i < 4; i++) begin
            if (spike_in[i] && (cnt[i] != 8'hff)) cnt_next[i] = cnt[i] + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
            cnt   <= '0;
            lat   <= '0;
        end else if (ena) begin
            timer <= timer + TIMER_ONE;
            if (win_end) begin
                lat <= cnt_next;
                cnt <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

    // Handshake: a transfer happens on an edge with rate_valid && rate_ready. rate_valid then
    // drops unless a window end reloads the latch in that same cycle. A window end while
    // rate_valid && !rate_ready overwrites unread data and sets the sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_valid  <= 1'b0;
            window_tick <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            window_tick <= win_end;
            if (win_end) begin
                rate_valid <= 1'b1;
                if (rate_valid && !rate_ready) overrun <= 1'b1;
            end else if (rate_valid && rate_ready) begin
                rate_valid <= 1'b0;
            end
        end
    end

    assign rate_out = lat[sel];

`ifdef SPIKE_DEC_THRESH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_hit <= 4'b0000;
        end else if (win_end) begin
            for (int i = 0; i < 4; i++) thresh_hit[i] <= (cnt_next[i] >= THRESH);
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign thresh_hit    = 4'b0000;
`endif

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter WIN_LOG2, default 8, sets the window length to 2^WIN_LOG2 clk cycles; legal range 2..16.
REQ-002 Parameter THRESH, 8-bit, default 8'd128, sets the rate threshold used by REQ-026.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  count enable; high = window timer and counters advance.
REQ-006 spike_in  input  4  one spike line per neuron channel; a high sample on a rising clk edge is one spike.
REQ-007 sel  input  2  channel select for rate_out.
REQ-008 rate_out  output  8  latched spike count of channel sel; combinational mux of the latched registers.
REQ-009 rate_valid  output  1  latched rates available.
REQ-010 rate_ready  input  1  consumer accepts the latched rates.
REQ-011 window_tick  output  1  one-cycle pulse, registered, in the cycle after each window end.
REQ-012 overrun  output  1  sticky flag: latched rates were overwritten before they were accepted.
REQ-013 thresh_hit  output  4  per-channel threshold flags (see Configuration).

Function
REQ-014 Window timer: WIN_LOG2-bit up-counter; increments on each clk while ena=1; wraps from 2^WIN_LOG2-1 to 0.
REQ-015 Window end = a cycle with ena=1 and timer = 2^WIN_LOG2-1.
REQ-016 Per-channel 8-bit spike counter: +1 per cycle with ena=1 and spike_in[i]=1; saturates at 255 with no wrap.
REQ-017 At window end, the latch register of each channel SHALL receive sat255(counter + spike_in[i]), so a spike in the final cycle is included; all counters clear to 0 in the same edge.
REQ-018 Latency: latched values, rate_valid=1 and window_tick=1 are all visible in the cycle after the window end.
REQ-019 ena=0: timer and counters hold, spikes are ignored, no window end occurs; the handshake and the rate_out mux keep operating.
REQ-020 Handshake: a transfer occurs on a clk edge with rate_valid=1 and rate_ready=1; rate_valid then falls unless a window end happens in the same cycle.
REQ-021 Window end while rate_valid=1 and rate_ready=1: counts the data as consumed; the new latch is loaded; rate_valid stays 1; overrun is unchanged.
REQ-022 Window end while rate_valid=1 and rate_ready=0: the new latch overwrites the old one; rate_valid stays 1; overrun is set.
REQ-023 overrun clears only on reset.
REQ-024 rate_ready has no effect while rate_valid=0.

Reset
REQ-025 rst=1 asynchronously clears: timer, counters, latches, rate_valid, window_tick, overrun and thresh_hit, all to 0; rate_out therefore reads 0; a partial window in progress is discarded; counting restarts from timer 0 on the first edge after release.

Configuration
REQ-026 With macro SPIKE_DEC_THRESH_EN defined, thresh_hit[i] is registered alongside the latch as (latched value >= THRESH), and is updated only at window ends.
REQ-027 With SPIKE_DEC_THRESH_EN undefined, thresh_hit is constant 4'b0000 and no compare logic is built; all other behaviour is identical.

Verification (WIN_LOG2=4, i.e. 16-cycle window, THRESH=8'd5)
REQ-028 Drive spike_in=4'b0001 for all 16 cycles with ena=1 and rate_ready=0 -> in cycle 17, rate_valid=1 and window_tick=1; rate_out is 16 with sel=0 and 0 with sel=1..3; thresh_hit is 4'b0001 with the macro and 4'b0000 without it.
REQ-029 Hold spike_in[2]=1 continuously with WIN_LOG2=9 -> the channel 2 latch reads 255 (saturated), not 0 or 256 mod 256.
REQ-030 Pulse spike_in[1] only in the final window cycle -> latched rate_out(sel=1)=1, and channel 1 of the next window starts at 0.
REQ-031 Leave rate_ready=0 across two window ends -> overrun=1 after the second end and the latch holds the second window's counts; then set rate_ready=1 for one cycle -> rate_valid=0 and overrun stays 1.
REQ-032 Deassert ena for 5 cycles mid-window while spiking -> the window end is delayed by exactly 5 cycles and the counts exclude the spikes driven during ena=0.
REQ-033 Assert rst for 1 cycle mid-window with rate_valid=1 -> all outputs read 0 immediately (asynchronously); the next window_tick occurs 16 enabled cycles after rst is released.
